chroma_mode_select8x8: RTL and testbench

- Downstream consumer of the 8x8 chroma residual stage.
- Takes the three 64-sample residual blocks (vertical, horizontal, DC) and accumulates a sum of absolute differences (SAD) per mode, one row per cycle.
- Selects the lowest-cost intra chroma mode and reports it, with all three SADs, to the transform/mode-control logic.
- Uses a start/done handshake; the inputs are captured on start, so upstream may change them immediately afterwards.

---
 rtl/chroma_mode_select8x8.sv | 202 ++++++++++++++++++++
 tb/tb_chroma_mode_select8x8.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/chroma_mode_select8x8.sv
// 8x8 intra chroma mode decision: accumulates per-mode SAD over captured residual
// blocks one row per cycle and reports the lowest-cost mode with a start/done handshake.
module chroma_mode_select8x8 #(
  parameter int BLK   = 8,
  parameter int SAD_W = 14
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [BLK*BLK*8-1:0]   vres,
  input  logic [BLK*BLK*8-1:0]   hres,
  input  logic [BLK*BLK*8-1:0]   dcres,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             mode,
  output logic [SAD_W-1:0]       best_sad,
  output logic [SAD_W-1:0]       sad_v,
  output logic [SAD_W-1:0]       sad_h,
  output logic [SAD_W-1:0]       sad_dc
);

  localparam int ROW_W = BLK * 8;
  localparam int BUF_W = BLK * BLK * 8;
  localparam int CNT_W = (BLK > 1) ? $clog2(BLK) : 1;

  localparam logic [1:0] MODE_DC = 2'd0;
  localparam logic [1:0] MODE_H  = 2'd1;
  localparam logic [1:0] MODE_V  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_DECIDE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   row_cnt_q, row_cnt_d;
  logic [BUF_W-1:0]   vbuf_q, vbuf_d;
  logic [BUF_W-1:0]   hbuf_q, hbuf_d;
  logic [BUF_W-1:0]   dbuf_q, dbuf_d;
  logic [SAD_W-1:0]   acc_v_q, acc_v_d;
  logic [SAD_W-1:0]   acc_h_q, acc_h_d;
  logic [SAD_W-1:0]   acc_dc_q, acc_dc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [1:0]         mode_q, mode_d;
  logic [SAD_W-1:0]   best_sad_q, best_sad_d;
  logic [SAD_W-1:0]   sad_v_q, sad_v_d;
  logic [SAD_W-1:0]   sad_h_q, sad_h_d;
  logic [SAD_W-1:0]   sad_dc_q, sad_dc_d;

  logic [ROW_W-1:0]   vrow_s, hrow_s, drow_s;
  logic [1:0]         sel_mode_s;
  logic [SAD_W-1:0]   sel_sad_s;

  // -128 wraps back to 0x80, which read unsigned is the required 128.
  function automatic logic [7:0] abs8(input logic [7:0] r);
    logic [7:0] a;
    if (r[7]) begin
      a = 8'd0 - r;
    end else begin
      a = r;
    end
    return a;
  endfunction

  function automatic logic [SAD_W-1:0] row_sad(input logic [ROW_W-1:0] row);
    logic [SAD_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < BLK; i++) begin
      acc = acc + SAD_W'(abs8(row[i*8 +: 8]));
    end
    return acc;
  endfunction

  always_comb begin
    vrow_s = vbuf_q[int'(row_cnt_q)*ROW_W +: ROW_W];
    hrow_s = hbuf_q[int'(row_cnt_q)*ROW_W +: ROW_W];
    drow_s = dbuf_q[int'(row_cnt_q)*ROW_W +: ROW_W];
  end

  // Strict minimum, ties favour DC, then horizontal, then vertical.
  always_comb begin
    sel_mode_s = MODE_V;
    sel_sad_s  = acc_v_q;
    if ((acc_dc_q <= acc_h_q) && (acc_dc_q <= acc_v_q)) begin
      sel_mode_s = MODE_DC;
      sel_sad_s  = acc_dc_q;
    end else if (acc_h_q <= acc_v_q) begin
      sel_mode_s = MODE_H;
      sel_sad_s  = acc_h_q;
    end else begin
      sel_mode_s = MODE_V;
      sel_sad_s  = acc_v_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    vbuf_d     = vbuf_q;
    hbuf_d     = hbuf_q;
    dbuf_d     = dbuf_q;
    acc_v_d    = acc_v_q;
    acc_h_d    = acc_h_q;
    acc_dc_d   = acc_dc_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mode_d     = mode_q;
    best_sad_d = best_sad_q;
    sad_v_d    = sad_v_q;
    sad_h_d    = sad_h_q;
    sad_dc_d   = sad_dc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          vbuf_d    = vres;
          hbuf_d    = hres;
          dbuf_d    = dcres;
          acc_v_d   = '0;
          acc_h_d   = '0;
          acc_dc_d  = '0;
          row_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = ST_ACCUM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        acc_v_d   = acc_v_q + row_sad(vrow_s);
        acc_h_d   = acc_h_q + row_sad(hrow_s);
        acc_dc_d  = acc_dc_q + row_sad(drow_s);
        row_cnt_d = row_cnt_q + CNT_W'(1);
        if (row_cnt_q == CNT_W'(BLK - 1)) begin
          state_d = ST_DECIDE;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_DECIDE: begin
        sad_v_d    = acc_v_q;
        sad_h_d    = acc_h_q;
        sad_dc_d   = acc_dc_q;
        mode_d     = sel_mode_s;
        best_sad_d = sel_sad_s;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      row_cnt_q  <= '0;
      vbuf_q     <= '0;
      hbuf_q     <= '0;
      dbuf_q     <= '0;
      acc_v_q    <= '0;
      acc_h_q    <= '0;
      acc_dc_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mode_q     <= MODE_DC;
      best_sad_q <= '0;
      sad_v_q    <= '0;
      sad_h_q    <= '0;
      sad_dc_q   <= '0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      vbuf_q     <= vbuf_d;
      hbuf_q     <= hbuf_d;
      dbuf_q     <= dbuf_d;
      acc_v_q    <= acc_v_d;
      acc_h_q    <= acc_h_d;
      acc_dc_q   <= acc_dc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mode_q     <= mode_d;
      best_sad_q <= best_sad_d;
      sad_v_q    <= sad_v_d;
      sad_h_q    <= sad_h_d;
      sad_dc_q   <= sad_dc_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mode     = mode_q;
  assign best_sad = best_sad_q;
  assign sad_v    = sad_v_q;
  assign sad_h    = sad_h_q;
  assign sad_dc   = sad_dc_q;

endmodule

// File: tb/tb_chroma_mode_select8x8.sv
// Directed self-checking bench for chroma_mode_select8x8 with hand-computed SADs.
module tb_chroma_mode_select8x8;

  typedef logic [511:0] blk_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  blk_t        vres, hres, dcres;
  logic        busy, done;
  logic [1:0]  mode;
  logic [13:0] best_sad, sad_v, sad_h, sad_dc;

  int n_pass;
  int n_total;

  chroma_mode_select8x8 #(.BLK(8), .SAD_W(14)) dut (
    .clk(clk), .reset(rst_n), .start(start),
    .vres(vres), .hres(hres), .dcres(dcres),
    .busy(busy), .done(done), .mode(mode), .best_sad(best_sad),
    .sad_v(sad_v), .sad_h(sad_h), .sad_dc(sad_dc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic blk_t fill(input logic [7:0] b);
    return {64{b}};
  endfunction

  task automatic chk_out(input string tag, input int ev, input int eh, input int ed,
                         input int em, input int eb);
    chk({tag, ".sad_v"}, 32'(sad_v), ev);
    chk({tag, ".sad_h"}, 32'(sad_h), eh);
    chk({tag, ".sad_dc"}, 32'(sad_dc), ed);
    chk({tag, ".mode"}, 32'(mode), em);
    chk({tag, ".best"}, 32'(best_sad), eb);
  endtask

  // One block from an idle DUT: checks handshake timing and the results.
  task automatic run_block(input string tag, input blk_t v, input blk_t h, input blk_t d,
                           input int ev, input int eh, input int ed, input int em, input int eb);
    int lat;
    @(negedge clk);
    vres = v; hres = h; dcres = d; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    vres = fill(8'h7F); hres = fill(8'h7F); dcres = fill(8'h7F);
    chk({tag, ".busy_on"}, 32'(busy), 32'd1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({tag, ".latency"}, 32'(lat), 32'd9);
    chk({tag, ".busy_off"}, 32'(busy), 32'd0);
    chk_out(tag, ev, eh, ed, em, eb);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  blk_t v4;
  blk_t sv [3], sh [3], sd [3];
  int   e_v [3], e_h [3], e_d [3], e_m [3], e_b [3];
  int   spurious;

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0; start = 1'b0;
    vres = '0; hres = '0; dcres = '0;
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk_out("rst", 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_block("zero", '0, '0, '0, 0, 0, 0, 0, 0);
    run_block("hv_tie", fill(8'h01), fill(8'hFF), fill(8'h02), 64, 64, 128, 1, 64);
    run_block("max", fill(8'h80), fill(8'h7F), fill(8'h81), 8192, 8128, 8128, 0, 8128);
    v4 = '0;
    v4[511:448] = {8{8'h05}};
    run_block("row7", v4, fill(8'h03), fill(8'h03), 40, 192, 192, 2, 40);

    // Back-to-back with start held high; inputs altered right after each accept.
    sv[0] = fill(8'h01); sh[0] = fill(8'hFF); sd[0] = fill(8'h02);
    e_v[0] = 64;  e_h[0] = 64;  e_d[0] = 128; e_m[0] = 1; e_b[0] = 64;
    sv[1] = fill(8'h01); sh[1] = fill(8'h04); sd[1] = fill(8'hFD);
    e_v[1] = 64;  e_h[1] = 256; e_d[1] = 192; e_m[1] = 2; e_b[1] = 64;
    sv[2] = fill(8'hFB); sh[2] = fill(8'h05); sd[2] = '0;
    e_v[2] = 320; e_h[2] = 320; e_d[2] = 0;   e_m[2] = 0; e_b[2] = 0;
    @(negedge clk);
    vres = sv[0]; hres = sh[0]; dcres = sd[0]; start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      if (j < 2) begin
        vres = sv[j+1]; hres = sh[j+1]; dcres = sd[j+1];
      end else begin
        start = 1'b0;
        vres = fill(8'h80); hres = fill(8'h80); dcres = fill(8'h80);
      end
      spurious = 0;
      repeat (8) begin
        @(negedge clk);
        if (done) spurious++;
      end
      chk($sformatf("b2b%0d.early_done", j), 32'(spurious), 32'd0);
      @(negedge clk);
      chk($sformatf("b2b%0d.done", j), 32'(done), 32'd1);
      chk_out($sformatf("b2b%0d", j), e_v[j], e_h[j], e_d[j], e_m[j], e_b[j]);
      if (j < 2) @(posedge clk);
    end
    @(negedge clk);
    chk("b2b.idle_done", 32'(done), 32'd0);
    chk("b2b.idle_busy", 32'(busy), 32'd0);

    // Reset asserted mid-block: immediate clear and no done for the aborted block.
    @(negedge clk);
    vres = fill(8'h02); hres = fill(8'h02); dcres = fill(8'h02); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk_out("abort", 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    chk("abort.no_done", 32'(spurious), 32'd0);
    run_block("after_abort", fill(8'h01), fill(8'hFF), fill(8'h02), 64, 64, 128, 1, 64);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
